// File: rtl/usb_timer_pkg.sv
// usb_timer_pkg: shared constants and mode encodings for the multi_counter
// timing bank used by the USB frame, timeout and retry paths.
//   DEF_NUM_CH / DEF_WIDTH : default channel count and counter width
//   mode_e                 : wrap or saturate at the terminal value
//   dir_e                  : count direction
package usb_timer_pkg;

  localparam int unsigned DEF_NUM_CH = 4;
  localparam int unsigned DEF_WIDTH  = 8;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/counter_ch.sv
// counter_ch: one channel of the multi_counter bank.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   clr             : synchronous clear (count and tc to zero)
//   en, dir, sat    : count enable, direction (1 up), mode (1 saturate)
//   load, load_val  : load strobe and value (clamped to limit)
//   limit           : terminal value
//   count, tc       : registered count and terminal-count pulse
//   tc_next         : next-state tc, lets the parent register an aligned OR
module counter_ch
  import usb_timer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             dir,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             tc_next
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  mode_e            mode;
  dir_e             direction;

  always_comb begin
    mode      = mode_e'(sat);
    direction = dir_e'(dir);
  end

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = (load_val > limit) ? limit : load_val;
    end else if (en) begin
      if (direction == DIR_UP) begin
        if (count_q < limit) begin
          count_d = count_q + 1'b1;
        end else if (mode == MODE_WRAP) begin
          count_d = '0;
          tc_d    = 1'b1;
        end else begin
          // Saturated: pulse only when arriving at limit from above.
          count_d = limit;
          tc_d    = (count_q != limit);
        end
      end else begin
        if (count_q > limit) begin
          // Limit was lowered under us: resync silently.
          count_d = limit;
        end else if (count_q != '0) begin
          count_d = count_q - 1'b1;
          tc_d    = (mode == MODE_SAT) && (count_q == WIDTH'(1));
        end else if (mode == MODE_WRAP) begin
          count_d = limit;
          tc_d    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign tc_next = tc_d;

endmodule

// File: rtl/multi_counter.sv
// multi_counter: bank of NUM_CH independent WIDTH-bit counters with enable,
// direction, load, programmable terminal value and wrap/saturate mode.
// Ports:
//   clk, reset, clr          : clock, sync active-high reset, global clear
//   en, dir, sat, load       : per-channel controls (one bit per channel)
//   load_val, limit, count   : packed, channel i at [i*WIDTH +: WIDTH]
//   tc, any_tc               : per-channel terminal pulse and registered OR
//   cap_stb, cap_count,
//   cap_valid                : snapshot of all counts, present only when
//                              MULTI_COUNTER_CAPTURE_EN is defined
module multi_counter
  import usb_timer_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned WIDTH  = DEF_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       dir,
  input  logic [NUM_CH-1:0]       sat,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] load_val,
  input  logic [NUM_CH*WIDTH-1:0] limit,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic [NUM_CH-1:0]       tc,
  output logic                    any_tc
`ifdef MULTI_COUNTER_CAPTURE_EN
  ,
  input  logic                    cap_stb,
  output logic [NUM_CH*WIDTH-1:0] cap_count,
  output logic                    cap_valid
`endif
);

  logic [NUM_CH-1:0] tc_next;
  logic              any_tc_q, any_tc_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    counter_ch #(.WIDTH(WIDTH)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .clr      (clr),
      .en       (en[i]),
      .dir      (dir[i]),
      .sat      (sat[i]),
      .load     (load[i]),
      .load_val (load_val[i*WIDTH +: WIDTH]),
      .limit    (limit[i*WIDTH +: WIDTH]),
      .count    (count[i*WIDTH +: WIDTH]),
      .tc       (tc[i]),
      .tc_next  (tc_next[i])
    );
  end

  // Registered from next-state tc so any_tc lines up with tc.
  always_comb begin
    any_tc_d = |tc_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      any_tc_q <= 1'b0;
    end else begin
      any_tc_q <= any_tc_d;
    end
  end

  assign any_tc = any_tc_q;

`ifdef MULTI_COUNTER_CAPTURE_EN
  logic [NUM_CH*WIDTH-1:0] cap_count_q, cap_count_d;
  logic                    cap_valid_q, cap_valid_d;

  // count is the registered value, so a strobe alongside load/clr
  // snapshots the pre-edge counts.
  always_comb begin
    cap_count_d = cap_count_q;
    cap_valid_d = cap_valid_q;
    if (cap_stb) begin
      cap_count_d = count;
      cap_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_count_q <= '0;
      cap_valid_q <= 1'b0;
    end else begin
      cap_count_q <= cap_count_d;
      cap_valid_q <= cap_valid_d;
    end
  end

  assign cap_count = cap_count_q;
  assign cap_valid = cap_valid_q;
`endif

endmodule

// File: tb/tb_multi_counter.sv
// tb_multi_counter: directed scenarios plus randomized traffic for
// multi_counter, every cycle compared against a behavioural model.
// Define MULTI_COUNTER_CAPTURE_EN to also exercise the capture ports.
module tb_multi_counter;

  localparam int NCH = 4;
  localparam int W   = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             clr;
  logic [NCH-1:0]   en, dir, sat, load;
  logic [NCH*W-1:0] load_val, limit;
  logic [NCH*W-1:0] count;
  logic [NCH-1:0]   tc;
  logic             any_tc;
`ifdef MULTI_COUNTER_CAPTURE_EN
  logic             cap_stb;
  logic [NCH*W-1:0] cap_count;
  logic             cap_valid;
`endif

  multi_counter #(.NUM_CH(NCH), .WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .en       (en),
    .dir      (dir),
    .sat      (sat),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .count    (count),
    .tc       (tc),
    .any_tc   (any_tc)
`ifdef MULTI_COUNTER_CAPTURE_EN
    ,
    .cap_stb  (cap_stb),
    .cap_count(cap_count),
    .cap_valid(cap_valid)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state
  int unsigned m_count [NCH];
  bit          m_tc    [NCH];
  bit          m_any;
`ifdef MULTI_COUNTER_CAPTURE_EN
  int unsigned m_cap   [NCH];
  bit          m_cap_v;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned fld(input logic [NCH*W-1:0] v, input int i);
    return int'(v[i*W +: W]);
  endfunction

  // Apply the per-channel rules with plain integer arithmetic.
  task automatic model_edge();
    int unsigned old [NCH];
    int unsigned c, l;
    for (int i = 0; i < NCH; i++) old[i] = m_count[i];
`ifdef MULTI_COUNTER_CAPTURE_EN
    if (reset) begin
      m_cap_v = 1'b0;
      for (int i = 0; i < NCH; i++) m_cap[i] = 0;
    end else if (cap_stb) begin
      m_cap_v = 1'b1;
      for (int i = 0; i < NCH; i++) m_cap[i] = old[i];
    end
`endif
    m_any = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      c = old[i];
      l = fld(limit, i);
      m_tc[i] = 1'b0;
      if (reset || clr) begin
        c = 0;
      end else if (load[i]) begin
        c = (fld(load_val, i) < l) ? fld(load_val, i) : l;
      end else if (en[i]) begin
        if (dir[i]) begin
          if (c < l) c = c + 1;
          else if (!sat[i]) begin c = 0; m_tc[i] = 1'b1; end
          else begin m_tc[i] = (c != l); c = l; end
        end else begin
          if (c > l) c = l;
          else if (c > 0) begin m_tc[i] = sat[i] && (c == 1); c = c - 1; end
          else if (!sat[i]) begin c = l; m_tc[i] = 1'b1; end
        end
      end
      m_count[i] = c;
      m_any = m_any | m_tc[i];
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NCH; i++) begin
      check($sformatf("count%0d", i), 64'(fld(count, i)), 64'(m_count[i]));
      check($sformatf("tc%0d", i), 64'(tc[i]), 64'(m_tc[i]));
    end
    check("any_tc", 64'(any_tc), 64'(m_any));
`ifdef MULTI_COUNTER_CAPTURE_EN
    for (int i = 0; i < NCH; i++)
      check($sformatf("cap%0d", i), 64'(fld(cap_count, i)), 64'(m_cap[i]));
    check("cap_valid", 64'(cap_valid), 64'(m_cap_v));
`endif
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_ch(input int i, input logic [W-1:0] lim, input logic [W-1:0] lv);
    limit[i*W +: W]    = lim;
    load_val[i*W +: W] = lv;
  endtask

  task automatic idle();
    clr = 0; en = '0; load = '0;
`ifdef MULTI_COUNTER_CAPTURE_EN
    cap_stb = 0;
`endif
  endtask

  initial begin
    reset = 1; clr = 0; en = '0; dir = '0; sat = '0; load = '0;
    load_val = '0; limit = '0;
`ifdef MULTI_COUNTER_CAPTURE_EN
    cap_stb = 0;
`endif
    for (int i = 0; i < NCH; i++) m_count[i] = 0;
    #2;
    repeat (3) step();
    check("reset_count", 64'(count), 64'd0);
    reset = 0;

    // ch0: up, wrap, limit 9
    set_ch(0, 8'd9, 8'd0); dir[0] = 1; sat[0] = 0; en[0] = 1;
    repeat (9) step();
    check("ch0_at_limit", 64'(fld(count, 0)), 64'd9);
    step();
    check("ch0_wrap_tc", 64'(tc[0]), 64'd1);
    check("ch0_wrap_any", 64'(any_tc), 64'd1);
    idle();

    // ch1: down, saturate, from 3
    set_ch(1, 8'd10, 8'd3); dir[1] = 0; sat[1] = 1; load[1] = 1;
    step();
    load[1] = 0; en[1] = 1;
    repeat (2) step();
    check("ch1_at_1", 64'(fld(count, 1)), 64'd1);
    step();
    check("ch1_tc_1to0", 64'(tc[1]), 64'd1);
    repeat (3) step();
    check("ch1_hold_notc", 64'(tc[1]), 64'd0);
    idle();

    // ch2: load clamped to limit, en ignored, then wrap
    set_ch(2, 8'd100, 8'd200); dir[2] = 1; sat[2] = 0; load[2] = 1; en[2] = 1;
    step();
    check("ch2_clamp", 64'(fld(count, 2)), 64'd100);
    load[2] = 0;
    step();
    check("ch2_wrap_tc", 64'(tc[2]), 64'd1);
    idle();

    // ch3: up saturate to 5, then limit lowered to 3, then down
    set_ch(3, 8'd5, 8'd0); dir[3] = 1; sat[3] = 1; en[3] = 1;
    repeat (6) step();
    check("ch3_sat", 64'(fld(count, 3)), 64'd5);
    set_ch(3, 8'd3, 8'd0);
    step();
    check("ch3_resync", 64'(fld(count, 3)), 64'd3);
    dir[3] = 0;
    step();
    check("ch3_down", 64'(fld(count, 3)), 64'd2);
    idle();

    // clr beats load on all channels mid-count
    en = '1; dir = '1; sat = '0;
    for (int i = 0; i < NCH; i++) set_ch(i, 8'd50, 8'd20);
    repeat (4) step();
    clr = 1; load = '1;
    step();
    check("clr_counts", 64'(count), 64'd0);
    check("clr_tc", 64'(tc), 64'd0);
    clr = 0; load = '0;
    repeat (3) step();
    reset = 1;
    step();
    check("reset_mid", 64'(count), 64'd0);
    reset = 0;
    step();

`ifdef MULTI_COUNTER_CAPTURE_EN
    idle();
    set_ch(0, 8'd20, 8'd7); load[0] = 1;
    step();
    set_ch(0, 8'd20, 8'd12); cap_stb = 1;
    step();
    check("cap_ch0", 64'(fld(cap_count, 0)), 64'd7);
    check("cap_v", 64'(cap_valid), 64'd1);
    check("cap_live", 64'(fld(count, 0)), 64'd12);
    idle();
`endif

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      clr   = ($urandom_range(0, 49) == 0);
`ifdef MULTI_COUNTER_CAPTURE_EN
      cap_stb = ($urandom_range(0, 9) == 0);
`endif
      for (int i = 0; i < NCH; i++) begin
        en[i]   = ($urandom_range(0, 3) != 0);
        load[i] = ($urandom_range(0, 11) == 0);
        if ($urandom_range(0, 15) == 0) dir[i] = ~dir[i];
        if ($urandom_range(0, 15) == 0) sat[i] = ~sat[i];
        if ($urandom_range(0, 19) == 0)
          limit[i*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 12));
        load_val[i*W +: W] = ($urandom_range(0, 1) == 0) ? W'($urandom) : W'($urandom_range(0, 12));
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
